// File: rtl/cont_ring_sequencer.sv
// N-stage continuation sequencer: hands a level start around a ring of stages,
// advancing on the active stage's done, with pass counting, stop and watchdog.
module cont_ring_sequencer #(
  parameter int NUM_STAGES      = 3,
  parameter int STAGE_BITS      = 2,
  parameter int PASS_COUNT_BITS = 8,
  parameter int TIMEOUT_BITS    = 16,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic                       Clck,
  input  logic                       Reset,
  input  logic                       working,
  input  logic                       continuous,
  input  logic                       stop,
  input  logic [NUM_STAGES-1:0]      stage_done,
  output logic [NUM_STAGES-1:0]      stage_start,
  output logic [STAGE_BITS-1:0]      cur_stage,
  output logic                       busy,
  output logic                       pass_done,
  output logic [PASS_COUNT_BITS-1:0] pass_count,
  output logic                       timeout_err
);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  localparam logic [STAGE_BITS-1:0]   LAST_STAGE = STAGE_BITS'(NUM_STAGES - 1);
  localparam logic [TIMEOUT_BITS-1:0] WD_LIMIT   = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
  localparam bit                      WD_ENABLE  = (TIMEOUT_CYCLES != 0);

  state_t                  state;
  logic                    stop_latch;
  logic [TIMEOUT_BITS-1:0] wd_count;

  logic active_done;
  logic stop_now;
  logic at_last;
  logic wd_expired;

  // Masking done with the registered one-hot start ignores every inactive stage.
  assign active_done = |(stage_done & stage_start);
  assign stop_now    = stop_latch | stop;
  assign at_last     = (cur_stage == LAST_STAGE);
  assign wd_expired  = WD_ENABLE && (wd_count == WD_LIMIT);

  always_ff @(posedge Clck) begin
    if (Reset) begin
      state       <= IDLE;
      stage_start <= '0;
      cur_stage   <= '0;
      busy        <= 1'b0;
      pass_done   <= 1'b0;
      pass_count  <= '0;
      timeout_err <= 1'b0;
      stop_latch  <= 1'b0;
      wd_count    <= '0;
    end else begin
      pass_done <= 1'b0;
      case (state)
        IDLE: begin
          if (working && !stop) begin
            state       <= RUN;
            stage_start <= NUM_STAGES'(1);
            cur_stage   <= '0;
            busy        <= 1'b1;
            wd_count    <= '0;
          end
        end

        RUN: begin
          if (stop) stop_latch <= 1'b1;
          if (active_done) begin
            wd_count <= '0;
            if (at_last) begin
              pass_done  <= 1'b1;
              pass_count <= pass_count + PASS_COUNT_BITS'(1);
              cur_stage  <= '0;
              // A stop arriving together with the final done still ends the ring.
              if (continuous && !stop_now) begin
                stage_start <= NUM_STAGES'(1);
              end else begin
                stage_start <= '0;
                busy        <= 1'b0;
                stop_latch  <= 1'b0;
                state       <= IDLE;
              end
            end else begin
              stage_start <= {stage_start[NUM_STAGES-2:0], 1'b0};
              cur_stage   <= cur_stage + STAGE_BITS'(1);
            end
          end else if (wd_expired) begin
            timeout_err <= 1'b1;
            stage_start <= '0;
            cur_stage   <= '0;
            busy        <= 1'b0;
            stop_latch  <= 1'b0;
            state       <= ERR;
          end else begin
            wd_count <= wd_count + TIMEOUT_BITS'(1);
          end
        end

        ERR: state <= ERR;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cont_ring_sequencer.sv
// Directed bench for cont_ring_sequencer: 3 stages, 8-cycle watchdog, plus a
// second 2-bit pass counter instance for the wrap scenario.
module tb_cont_ring_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0, working = 1'b0, continuous = 1'b0, stop = 1'b0;
  logic [2:0] done = '0;
  logic [2:0] stage_start;
  logic [1:0] cur_stage;
  logic       busy, pass_done, timeout_err;
  logic [7:0] pass_count;

  logic       rst_w = 1'b0, working_w = 1'b0, continuous_w = 1'b0, stop_w = 1'b0;
  logic [2:0] done_w = '0;
  logic [2:0] stage_start_w;
  logic [1:0] cur_stage_w;
  logic       busy_w, pass_done_w, timeout_err_w;
  logic [1:0] pass_count_w;

  int n_tests = 0;
  int n_fail  = 0;

  // Packed view: {stage_start, cur_stage, busy, pass_done, pass_count, timeout_err}
  wire [15:0] obs = {stage_start, cur_stage, busy, pass_done, pass_count, timeout_err};

  always #5 clk = ~clk;

  cont_ring_sequencer #(
    .NUM_STAGES(3), .STAGE_BITS(2), .PASS_COUNT_BITS(8),
    .TIMEOUT_BITS(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .Clck(clk), .Reset(rst), .working(working), .continuous(continuous),
    .stop(stop), .stage_done(done), .stage_start(stage_start),
    .cur_stage(cur_stage), .busy(busy), .pass_done(pass_done),
    .pass_count(pass_count), .timeout_err(timeout_err)
  );

  cont_ring_sequencer #(
    .NUM_STAGES(3), .STAGE_BITS(2), .PASS_COUNT_BITS(2),
    .TIMEOUT_BITS(16), .TIMEOUT_CYCLES(8)
  ) dut_wrap (
    .Clck(clk), .Reset(rst_w), .working(working_w), .continuous(continuous_w),
    .stop(stop_w), .stage_done(done_w), .stage_start(stage_start_w),
    .cur_stage(cur_stage_w), .busy(busy_w), .pass_done(pass_done_w),
    .pass_count(pass_count_w), .timeout_err(timeout_err_w)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [15:0] e;
    rst = 1'b1; working = 1'b1; continuous = 1'b0; stop = 1'b0; done = '0;
    tick; tick;
    rst = 1'b0; working = 1'b0;
    e = '0;
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL reset_state: got %h expected %h", obs, e); end
    tick;
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL reset_idle_hold: got %h expected %h", obs, e); end
  endtask

  task automatic test_one_shot;
    logic [2:0]  oh;
    logic [15:0] e;
    rst = 1'b1; tick; rst = 1'b0;
    continuous = 1'b0; working = 1'b1;
    tick;
    working = 1'b0;
    for (int k = 0; k < 3; k++) begin
      oh = 3'b001 << k;
      for (int c = 0; c < 2; c++) begin
        e = {oh, 2'(k), 1'b1, 1'b0, 8'd0, 1'b0};
        n_tests++;
        if (obs !== e) begin n_fail++; $display("[TB] FAIL one_shot_stage%0d_cyc%0d: got %h expected %h", k, c, obs, e); end
        done = (c == 1) ? oh : 3'b000;
        tick;
      end
    end
    done = '0;
    e = {3'b000, 2'd0, 1'b0, 1'b1, 8'd1, 1'b0};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL one_shot_end: got %h expected %h", obs, e); end
    tick;
    e = {3'b000, 2'd0, 1'b0, 1'b0, 8'd1, 1'b0};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL one_shot_idle: got %h expected %h", obs, e); end
  endtask

  task automatic test_continuous_stop;
    logic [2:0]  oh;
    logic [15:0] e;
    logic        pd;
    rst = 1'b1; tick; rst = 1'b0;
    continuous = 1'b1; working = 1'b1;
    tick;
    for (int p = 1; p <= 3; p++) begin
      for (int k = 0; k < 3; k++) begin
        oh = 3'b001 << k;
        for (int c = 0; c < 2; c++) begin
          pd = (p > 1 && k == 0 && c == 0);
          e = {oh, 2'(k), 1'b1, pd, 8'(p - 1), 1'b0};
          n_tests++;
          if (obs !== e) begin n_fail++; $display("[TB] FAIL cont_p%0d_s%0d_c%0d: got %h expected %h", p, k, c, obs, e); end
          stop = (p == 3 && k == 1 && c == 0);
          done = (c == 1) ? oh : 3'b000;
          tick;
        end
      end
    end
    done = '0; stop = 1'b0;
    e = {3'b000, 2'd0, 1'b0, 1'b1, 8'd3, 1'b0};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL cont_stop_end: got %h expected %h", obs, e); end
    working = 1'b0;
    tick;
    e = {3'b000, 2'd0, 1'b0, 1'b0, 8'd3, 1'b0};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL cont_stop_idle: got %h expected %h", obs, e); end
    continuous = 1'b0;
  endtask

  task automatic test_simultaneous;
    logic [15:0] e;
    rst = 1'b1; tick; rst = 1'b0;
    continuous = 1'b1; working = 1'b1;
    tick;
    working = 1'b0;
    e = {3'b001, 2'd0, 1'b1, 1'b0, 8'd0, 1'b0};
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (obs !== e) begin n_fail++; $display("[TB] FAIL sim_ignore_done2_c%0d: got %h expected %h", c, obs, e); end
      done = 3'b100;
      tick;
    end
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL sim_ignore_done2_last: got %h expected %h", obs, e); end
    done = 3'b001; tick;
    e = {3'b010, 2'd1, 1'b1, 1'b0, 8'd0, 1'b0};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL sim_stage1: got %h expected %h", obs, e); end
    done = 3'b010; tick;
    done = 3'b000;
    e = {3'b100, 2'd2, 1'b1, 1'b0, 8'd0, 1'b0};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL sim_stage2: got %h expected %h", obs, e); end
    tick;
    done = 3'b100; stop = 1'b1;
    tick;
    done = 3'b000; stop = 1'b0;
    e = {3'b000, 2'd0, 1'b0, 1'b1, 8'd1, 1'b0};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL sim_stop_and_done: got %h expected %h", obs, e); end
    tick;
    e = {3'b000, 2'd0, 1'b0, 1'b0, 8'd1, 1'b0};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL sim_no_restart: got %h expected %h", obs, e); end
    continuous = 1'b0;
  endtask

  task automatic test_watchdog;
    logic [15:0] e;
    rst = 1'b1; tick; rst = 1'b0;
    continuous = 1'b0; working = 1'b1;
    tick;
    working = 1'b0;
    done = 3'b001; tick; done = 3'b000;
    e = {3'b010, 2'd1, 1'b1, 1'b0, 8'd0, 1'b0};
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if (obs !== e) begin n_fail++; $display("[TB] FAIL wd_stage1_c%0d: got %h expected %h", c, obs, e); end
      tick;
    end
    e = {3'b000, 2'd0, 1'b0, 1'b0, 8'd0, 1'b1};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL wd_trip: got %h expected %h", obs, e); end
    working = 1'b1; done = 3'b111;
    for (int c = 0; c < 3; c++) begin
      tick;
      n_tests++;
      if (obs !== e) begin n_fail++; $display("[TB] FAIL wd_err_hold_c%0d: got %h expected %h", c, obs, e); end
    end
    working = 1'b0; done = 3'b000;
    rst = 1'b1; tick; rst = 1'b0;
    n_tests++;
    if (obs !== 16'h0000) begin n_fail++; $display("[TB] FAIL wd_reset_clear: got %h expected %h", obs, 16'h0000); end

    working = 1'b1; tick; working = 1'b0;
    done = 3'b001; tick;
    e = {3'b010, 2'd1, 1'b1, 1'b0, 8'd0, 1'b0};
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if (obs !== e) begin n_fail++; $display("[TB] FAIL wd_limit_c%0d: got %h expected %h", c, obs, e); end
      done = (c == 7) ? 3'b010 : 3'b000;
      tick;
    end
    e = {3'b100, 2'd2, 1'b1, 1'b0, 8'd0, 1'b0};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL wd_done_on_limit: got %h expected %h", obs, e); end
    done = 3'b100; tick; done = 3'b000;
    e = {3'b000, 2'd0, 1'b0, 1'b1, 8'd1, 1'b0};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL wd_pass_ok: got %h expected %h", obs, e); end
  endtask

  task automatic test_reset_mid;
    logic [2:0]  oh;
    logic [15:0] e;
    int          p, k;
    logic        pd;
    rst = 1'b1; tick; rst = 1'b0;
    continuous = 1'b1; working = 1'b1;
    tick;
    for (int i = 0; i < 17; i++) begin
      p  = i / 3 + 1;
      k  = i % 3;
      oh = 3'b001 << k;
      pd = (k == 0 && i > 0);
      e = {oh, 2'(k), 1'b1, pd, 8'(p - 1), 1'b0};
      n_tests++;
      if (obs !== e) begin n_fail++; $display("[TB] FAIL mid_step%0d: got %h expected %h", i, obs, e); end
      done = oh;
      tick;
    end
    done = 3'b000;
    e = {3'b100, 2'd2, 1'b1, 1'b0, 8'd5, 1'b0};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL mid_before_reset: got %h expected %h", obs, e); end
    rst = 1'b1; tick; rst = 1'b0;
    n_tests++;
    if (obs !== 16'h0000) begin n_fail++; $display("[TB] FAIL mid_reset_clear: got %h expected %h", obs, 16'h0000); end
    continuous = 1'b0;
    tick;
    e = {3'b001, 2'd0, 1'b1, 1'b0, 8'd0, 1'b0};
    n_tests++;
    if (obs !== e) begin n_fail++; $display("[TB] FAIL mid_fresh_start: got %h expected %h", obs, e); end
    working = 1'b0;
    rst = 1'b1; tick; rst = 1'b0;
  endtask

  task automatic test_wrap;
    logic [2:0] oh;
    logic [1:0] exp_wrap [5];
    exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_w = 1'b1; tick; rst_w = 1'b0;
    continuous_w = 1'b1; working_w = 1'b1;
    tick;
    working_w = 1'b0;
    for (int p = 1; p <= 5; p++) begin
      for (int k = 0; k < 3; k++) begin
        oh = 3'b001 << k;
        n_tests++;
        if (stage_start_w !== oh) begin n_fail++; $display("[TB] FAIL wrap_p%0d_s%0d_start: got %b expected %b", p, k, stage_start_w, oh); end
        done_w = oh;
        stop_w = (p == 5 && k == 2);
        tick;
      end
      done_w = 3'b000; stop_w = 1'b0;
      n_tests++;
      if ({pass_done_w, pass_count_w} !== {1'b1, exp_wrap[p-1]}) begin
        n_fail++;
        $display("[TB] FAIL wrap_count_p%0d: got done=%b count=%0d expected done=1 count=%0d", p, pass_done_w, pass_count_w, exp_wrap[p-1]);
      end
    end
    n_tests++;
    if (busy_w !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_idle: got busy=%b expected 0", busy_w); end
  endtask

  initial begin
    test_reset;
    test_one_shot;
    test_continuous_stop;
    test_simultaneous;
    test_watchdog;
    test_reset_mid;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
